// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on the device clock,
// ACK check and timeout supervision. Pads are open-drain; *_d=1 pulls the line low.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750000,
    parameter int unsigned FILT_CYC    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       txDone,
    output logic       txErr,
    output logic [1:0] txErrCode,
    output logic       rxInhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_o,
    output logic       ps2_clk_d,
    output logic       ps2_data_o,
    output logic       ps2_data_d
);

    localparam int unsigned INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FLT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAITIDLE,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    // bit 0 = clk, bit 1 = data
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [FLT_W-1:0] flt_cnt [2];
    logic             clk_prev;
    logic             clk_f;
    logic             data_f;
    logic             fall;

    logic [INH_W-1:0] inh_cnt;
    logic [INH_W-1:0] inh_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_nxt;
    logic [7:0]       sh_reg;
    logic [7:0]       sh_nxt;
    logic             par;
    logic             par_nxt;
    logic [1:0]       code_nxt;
    logic             clk_d_nxt;
    logic             data_d_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             tmo_run;
    logic             tmo_expired;

    assign ps2_clk_o  = 1'b0;
    assign ps2_data_o = 1'b0;

    assign clk_f  = filt[0];
    assign data_f = filt[1];
    assign fall   = clk_prev & ~clk_f;

    // Two-flop synchronizer followed by a hold-stable filter per line; idle lines read high
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            clk_prev   <= 1'b1;
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
        end else begin
            sync1    <= {ps2_data_i, ps2_clk_i};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_W'(FILT_CYC - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FLT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            sh_reg     <= '0;
            par        <= 1'b0;
            txErrCode  <= ERR_NONE;
            ps2_clk_d  <= 1'b0;
            ps2_data_d <= 1'b0;
            txReady    <= 1'b1;
            txDone     <= 1'b0;
            txErr      <= 1'b0;
            rxInhibit  <= 1'b0;
        end else begin
            state      <= state_nxt;
            inh_cnt    <= inh_nxt;
            tmo_cnt    <= tmo_nxt;
            bit_cnt    <= bit_nxt;
            sh_reg     <= sh_nxt;
            par        <= par_nxt;
            txErrCode  <= code_nxt;
            ps2_clk_d  <= clk_d_nxt;
            ps2_data_d <= data_d_nxt;
            txReady    <= (state_nxt == IDLE);
            txDone     <= done_nxt;
            txErr      <= err_nxt;
            rxInhibit  <= (state_nxt != IDLE);
        end
    end

    // Next state and next registered outputs; pad drives change together with the state
    always_comb begin
        state_nxt   = state;
        inh_nxt     = inh_cnt;
        tmo_nxt     = tmo_cnt;
        bit_nxt     = bit_cnt;
        sh_nxt      = sh_reg;
        par_nxt     = par;
        code_nxt    = txErrCode;
        clk_d_nxt   = ps2_clk_d;
        data_d_nxt  = ps2_data_d;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        tmo_run     = state inside {REQ, SHIFT, ACK, WAITIDLE};
        tmo_expired = (tmo_cnt <= TMO_W'(1));

        case (state)
            IDLE: begin
                clk_d_nxt  = 1'b0;
                data_d_nxt = 1'b0;
                if (txValid && txReady) begin
                    sh_nxt     = txData;
                    par_nxt    = ~^txData;
                    code_nxt   = ERR_NONE;
                    inh_nxt    = '0;
                    clk_d_nxt  = 1'b1;
                    data_d_nxt = (INHIBIT_CYC <= 1);
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                    state_nxt  = REQ;
                    clk_d_nxt  = 1'b0;
                    data_d_nxt = 1'b1;
                    tmo_nxt    = TMO_W'(TIMEOUT_CYC);
                    bit_nxt    = '0;
                end else begin
                    inh_nxt = inh_cnt + INH_W'(1);
                    // start bit goes out during the last inhibit cycle
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 2)) begin
                        data_d_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                bit_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (fall) begin
                    bit_nxt = bit_cnt + 4'd1;
                    if (bit_cnt < 4'd8) begin
                        data_d_nxt = ~sh_reg[0];
                        sh_nxt     = {1'b0, sh_reg[7:1]};
                    end else if (bit_cnt == 4'd8) begin
                        data_d_nxt = ~par;
                    end else begin
                        data_d_nxt = 1'b0;
                        state_nxt  = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    if (!data_f) begin
                        state_nxt = WAITIDLE;
                    end else begin
                        state_nxt  = ERR;
                        code_nxt   = ERR_NACK;
                        err_nxt    = 1'b1;
                        clk_d_nxt  = 1'b0;
                        data_d_nxt = 1'b0;
                    end
                end
            end
            WAITIDLE: begin
                if (clk_f && data_f) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE, ERR: begin
                state_nxt  = IDLE;
                clk_d_nxt  = 1'b0;
                data_d_nxt = 1'b0;
            end
            default: begin
                state_nxt  = IDLE;
                clk_d_nxt  = 1'b0;
                data_d_nxt = 1'b0;
            end
        endcase

        // Timeout supervision; a device fall in the expiry cycle still counts as progress
        if (tmo_run) begin
            if (fall) begin
                tmo_nxt = TMO_W'(TIMEOUT_CYC);
            end else if (tmo_expired && state_nxt == state) begin
                state_nxt  = ERR;
                code_nxt   = ERR_TIMEOUT;
                err_nxt    = 1'b1;
                clk_d_nxt  = 1'b0;
                data_d_nxt = 1'b0;
            end else begin
                tmo_nxt = tmo_cnt - TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device model that clocks frames,
// samples the host bits on the rising edge and answers with ACK or NACK.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 50;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned FLT  = 8;
    localparam int unsigned HALF = 40;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       txDone;
    logic       txErr;
    logic [1:0] txErrCode;
    logic       rxInhibit;
    logic       ps2_clk_o;
    logic       ps2_clk_d;
    logic       ps2_data_o;
    logic       ps2_data_d;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line;
    logic       data_line;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    logic [9:0] exp_q[$];

    assign clk_line  = !((ps2_clk_d && !ps2_clk_o) || dev_clk_low);
    assign data_line = !((ps2_data_d && !ps2_data_o) || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TMO),
        .FILT_CYC   (FLT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .txData    (txData),
        .txValid   (txValid),
        .txReady   (txReady),
        .txDone    (txDone),
        .txErr     (txErr),
        .txErrCode (txErrCode),
        .rxInhibit (rxInhibit),
        .ps2_clk_i (clk_line),
        .ps2_data_i(data_line),
        .ps2_clk_o (ps2_clk_o),
        .ps2_clk_d (ps2_clk_d),
        .ps2_data_o(ps2_data_o),
        .ps2_data_d(ps2_data_d)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (txDone === 1'b1) done_cnt++;
        if (txErr === 1'b1) err_cnt++;
        if (txDone === 1'b1 && txErr === 1'b1) both_cnt++;
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        txData  = b;
        txValid = 1'b1;
        exp_q.push_back({1'b1, ~^b, b});
        step();
        txValid = 1'b0;
    endtask

    // Device side of one frame; returns what it observed on the pads
    task automatic device_frame(input bit ack, input bit glitch, output int inh_len,
                                output logic first_d, output logic last_d, output logic req_d,
                                output logic held_d, output int lat0, output logic [9:0] bits,
                                output bit hung);
        int n;
        hung    = 1'b0;
        inh_len = 0;
        lat0    = 0;
        bits    = '0;
        last_d  = 1'bx;
        n = 0;
        while (ps2_clk_d !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) hung = 1'b1;
        first_d = ps2_data_d;
        while (ps2_clk_d === 1'b1 && inh_len < int'(4 * INH)) begin
            last_d = ps2_data_d;
            inh_len++;
            step();
        end
        req_d = ps2_data_d;
        repeat (10) step();
        if (glitch) begin
            for (int g = 0; g < 3; g++) begin
                dev_clk_low = 1'b1;
                repeat (3) step();
                dev_clk_low = 1'b0;
                repeat (20) step();
            end
        end
        held_d = ps2_data_d;
        for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            for (int c = 1; c <= int'(HALF); c++) begin
                step();
                if (k == 0 && lat0 == 0 && ps2_data_d !== 1'b1) lat0 = c;
            end
            bits[k]     = data_line;
            dev_clk_low = 1'b0;
            if (glitch) begin
                repeat (20) step();
                dev_clk_low = 1'b1;
                repeat (3) step();
                dev_clk_low = 1'b0;
                repeat (HALF - 23) step();
            end else begin
                repeat (HALF) step();
            end
        end
        dev_data_low = ack;
        repeat (10) step();
        dev_clk_low = 1'b1;
        repeat (HALF) step();
        dev_clk_low = 1'b0;
        repeat (HALF / 2) step();
        dev_data_low = 1'b0;
        repeat (HALF) step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        txValid = 1'b0;
        txData  = 8'h00;
        repeat (3) step();
        checks++;
        if ({txReady, txDone, txErr, rxInhibit} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_status: got rdy/done/err/inh=%b expected 1000",
                     {txReady, txDone, txErr, rxInhibit});
        end
        checks++;
        if ({txErrCode, ps2_clk_d, ps2_data_d, ps2_clk_o, ps2_data_o} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_pads: got code/clkd/datad/clko/datao=%b expected 000000",
                     {txErrCode, ps2_clk_d, ps2_data_d, ps2_clk_o, ps2_data_o});
        end
        reset = 1'b0;
        repeat (20) step();
        checks++;
        if (txReady !== 1'b1 || ps2_clk_d !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%b clkd=%b expected 1 0", txReady, ps2_clk_d);
        end
    endtask

    task automatic test_send_byte(input logic [7:0] b, input logic exp_par);
        int inh_len, lat0, d0, e0;
        logic first_d, last_d, req_d, held_d;
        logic [9:0] bits, expf;
        bit hung;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        checks++;
        if (ps2_clk_d !== 1'b1 || txReady !== 1'b0 || rxInhibit !== 1'b1) begin
            errors++;
            $display("FAIL accept_%h: got clkd=%b rdy=%b inh=%b expected 1 0 1", b, ps2_clk_d, txReady, rxInhibit);
        end
        device_frame(1'b1, 1'b0, inh_len, first_d, last_d, req_d, held_d, lat0, bits, hung);
        expf = exp_q.pop_front();
        checks++;
        if (hung || inh_len != int'(INH)) begin
            errors++;
            $display("FAIL inhibit_len_%h: got %0d expected %0d", b, inh_len, INH);
        end
        checks++;
        if ({first_d, last_d, req_d} !== 3'b011) begin
            errors++;
            $display("FAIL start_bit_%h: got first/last/req=%b expected 011", b, {first_d, last_d, req_d});
        end
        checks++;
        if (bits !== expf) begin
            errors++;
            $display("FAIL frame_%h: got %b expected %b", b, bits, expf);
        end
        checks++;
        if (bits[8] !== exp_par) begin
            errors++;
            $display("FAIL parity_%h: got %b expected %b", b, bits[8], exp_par);
        end
        if (b[0] == 1'b1) begin
            checks++;
            if (lat0 != int'(2 + FLT + 1)) begin
                errors++;
                $display("FAIL data_latency_%h: got %0d expected %0d", b, lat0, 2 + FLT + 1);
            end
        end
        checks++;
        if (done_cnt != d0 + 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL done_pulse_%h: got done=%0d err=%0d expected %0d %0d",
                     b, done_cnt - d0, err_cnt - e0, 1, 0);
        end
        checks++;
        if (txErrCode !== 2'd0 || txReady !== 1'b1 || ps2_clk_d !== 1'b0 || ps2_data_d !== 1'b0) begin
            errors++;
            $display("FAIL after_done_%h: got code=%0d rdy=%b clkd=%b datad=%b expected 0 1 0 0",
                     b, txErrCode, txReady, ps2_clk_d, ps2_data_d);
        end
    endtask

    task automatic test_nack();
        int inh_len, lat0, d0, e0;
        logic first_d, last_d, req_d, held_d;
        logic [9:0] bits, expf;
        bit hung;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        device_frame(1'b0, 1'b0, inh_len, first_d, last_d, req_d, held_d, lat0, bits, hung);
        expf = exp_q.pop_front();
        checks++;
        if (bits !== expf) begin
            errors++;
            $display("FAIL nack_frame: got %b expected %b", bits, expf);
        end
        checks++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            errors++;
            $display("FAIL nack_pulse: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (txErrCode !== 2'd1 || ps2_clk_d !== 1'b0 || ps2_data_d !== 1'b0 || txReady !== 1'b1) begin
            errors++;
            $display("FAIL nack_state: got code=%0d clkd=%b datad=%b rdy=%b expected 1 0 0 1",
                     txErrCode, ps2_clk_d, ps2_data_d, txReady);
        end
    endtask

    task automatic test_timeout();
        int n, cnt, e0;
        e0 = err_cnt;
        send(8'h12);
        n = 0;
        while (ps2_clk_d === 1'b1 && n < int'(4 * INH)) begin
            step();
            n++;
        end
        cnt = 0;
        while (txErr !== 1'b1 && cnt < int'(3 * TMO)) begin
            step();
            cnt++;
        end
        void'(exp_q.pop_front());
        checks++;
        if (cnt != int'(TMO)) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles expected %0d", cnt, TMO);
        end
        checks++;
        if (txErrCode !== 2'd2 || ps2_clk_d !== 1'b0 || ps2_data_d !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got code=%0d clkd=%b datad=%b expected 2 0 0",
                     txErrCode, ps2_clk_d, ps2_data_d);
        end
        step();
        checks++;
        if (txErr !== 1'b0 || txReady !== 1'b1 || err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b rdy=%b pulses=%0d expected 0 1 1",
                     txErr, txReady, err_cnt - e0);
        end
    endtask

    task automatic test_ignore_valid();
        int inh_len, lat0, d0;
        logic first_d, last_d, req_d, held_d;
        logic [9:0] bits, expf;
        bit hung;
        d0 = done_cnt;
        send(8'hED);
        fork
            device_frame(1'b1, 1'b0, inh_len, first_d, last_d, req_d, held_d, lat0, bits, hung);
            begin
                repeat (INH + 300) step();
                txData  = 8'h55;
                txValid = 1'b1;
                step();
                txValid = 1'b0;
                txData  = 8'h00;
            end
        join
        expf = exp_q.pop_front();
        checks++;
        if (bits !== expf) begin
            errors++;
            $display("FAIL busy_frame: got %b expected %b", bits, expf);
        end
        repeat (50) step();
        checks++;
        if (done_cnt != d0 + 1 || ps2_clk_d !== 1'b0 || txReady !== 1'b1 || txErrCode !== 2'd0) begin
            errors++;
            $display("FAIL busy_ignored: got done=%0d clkd=%b rdy=%b code=%0d expected 1 0 1 0",
                     done_cnt - d0, ps2_clk_d, txReady, txErrCode);
        end
    endtask

    task automatic test_reset_mid();
        int n, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h36);
        n = 0;
        while (ps2_clk_d === 1'b1 && n < int'(4 * INH)) begin
            step();
            n++;
        end
        repeat (10) step();
        for (int k = 0; k < 4; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) step();
            if (k < 3) begin
                dev_clk_low = 1'b0;
                repeat (HALF) step();
            end
        end
        checks++;
        if (ps2_data_d !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_bit3: got datad=%b expected 1", ps2_data_d);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({ps2_clk_d, ps2_data_d, txReady, rxInhibit, txDone, txErr} !== 6'b001000) begin
            errors++;
            $display("FAIL mid_reset: got clkd/datad/rdy/inh/done/err=%b expected 001000",
                     {ps2_clk_d, ps2_data_d, txReady, rxInhibit, txDone, txErr});
        end
        reset       = 1'b0;
        dev_clk_low = 1'b0;
        repeat (100) step();
        void'(exp_q.pop_front());
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || txReady !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_quiet: got done=%0d err=%0d rdy=%b expected 0 0 1",
                     done_cnt - d0, err_cnt - e0, txReady);
        end
    endtask

    task automatic test_glitch();
        int inh_len, lat0, d0;
        logic first_d, last_d, req_d, held_d;
        logic [9:0] bits, expf;
        bit hung;
        d0 = done_cnt;
        send(8'hED);
        device_frame(1'b1, 1'b1, inh_len, first_d, last_d, req_d, held_d, lat0, bits, hung);
        expf = exp_q.pop_front();
        checks++;
        if (held_d !== 1'b1) begin
            errors++;
            $display("FAIL glitch_hold: got datad=%b expected 1", held_d);
        end
        checks++;
        if (bits !== expf || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL glitch_frame: got %b done=%0d expected %b 1", bits, done_cnt - d0, expf);
        end
    endtask

    task automatic test_final();
        checks++;
        if (both_cnt != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL exclusive_pulses: got overlap=%0d pending=%0d expected 0 0",
                     both_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_send_byte(8'hED, 1'b1);
        test_send_byte(8'hF4, 1'b0);
        test_nack();
        test_timeout();
        test_ignore_valid();
        test_reset_mid();
        test_glitch();
        test_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
